// File: rtl/loader_pkg.sv
// loader_pkg: shared states and frame constants for the program loader
package loader_pkg;
   typedef enum logic [2:0] {IDLE, BASE, LEN, DATA, CHK, DONE, ERROR} state_t;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int BASE_RSV_HI = 7;
   localparam int BASE_RSV_LO = 5;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte stream in, memory write port and CPU control out
interface program_loader_if #(parameter int ADDR_W = 5);
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              cpu_reset;
   logic              load_done;
   logic              load_error;
   modport master (output in_valid, in_data,
                   input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, load_done, load_error);
   modport slave  (input  in_valid, in_data,
                   output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, load_done, load_error);
endinterface

// File: rtl/loader_checksum.sv
// loader_checksum: 8-bit wrapping accumulator; is_zero includes the byte on din
module loader_checksum (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       add_en,
   input  logic [7:0] din,
   output logic       is_zero
);
   logic [7:0] sum;
   always_ff @(posedge clk)
      if (!reset || clr) sum <= '0;
      else if (add_en) sum <= sum + din;
   assign is_zero = (sum + din) == 8'd0;
endmodule

// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream, writes the payload to CPU memory
// and releases the CPU from reset once the frame checksum verifies
module program_loader
   import loader_pkg::*;
#(
   parameter int         MEM_DEPTH = 32,
   parameter int         ADDR_W    = 5,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
   input logic              clk,
   input logic              reset,
   program_loader_if.slave  bus
);
   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [7:0]        len;
   logic [7:0]        idx;
   logic              accept;
   logic              is_sync;
   logic              rsv_bad;
   logic [8:0]        end_addr;
   logic              ck_zero;

   assign bus.in_ready = reset && (state inside {IDLE, BASE, LEN, DATA, CHK});
   assign accept       = bus.in_valid && bus.in_ready;
   assign is_sync      = bus.in_data == SYNC_BYTE;
   assign rsv_bad      = |bus.in_data[BASE_RSV_HI:BASE_RSV_LO];
   assign end_addr     = 9'(base) + 9'(bus.in_data);

   loader_checksum u_ck (
      .clk    (clk),
      .reset  (reset),
      .clr    (accept && state == IDLE && is_sync),
      .add_en (accept && (state inside {BASE, LEN, DATA, CHK})),
      .din    (bus.in_data),
      .is_zero(ck_zero)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         base           <= '0;
         len            <= '0;
         idx            <= '0;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         bus.cpu_reset  <= 1'b1;
         bus.load_done  <= 1'b0;
         bus.load_error <= 1'b0;
      end else begin
         bus.mem_we <= 1'b0;
         case (state)
            IDLE: if (accept && is_sync) begin
               state          <= BASE;
               bus.load_error <= 1'b0;
            end
            BASE: if (accept) begin
               state          <= rsv_bad ? ERROR : LEN;
               bus.load_error <= rsv_bad;
               base           <= ADDR_W'(bus.in_data);
            end
            LEN: if (accept) begin
               // bounds check here is what keeps DATA addresses from wrapping
               if (bus.in_data == 8'd0 || end_addr > 9'(MEM_DEPTH)) begin
                  state          <= ERROR;
                  bus.load_error <= 1'b1;
               end else begin
                  state <= DATA;
                  len   <= bus.in_data;
                  idx   <= '0;
               end
            end
            DATA: if (accept) begin
               bus.mem_we    <= 1'b1;
               bus.mem_addr  <= base + ADDR_W'(idx);
               bus.mem_wdata <= bus.in_data;
               idx           <= idx + 8'd1;
               state         <= (idx == len - 8'd1) ? CHK : DATA;
            end
            CHK: if (accept) begin
               state          <= ck_zero ? DONE : ERROR;
               bus.cpu_reset  <= !ck_zero;
               bus.load_done  <= ck_zero;
               bus.load_error <= !ck_zero;
            end
            DONE:    state <= DONE;
            ERROR:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frames with hand-computed expectations
module tb_program_loader;
   logic       clk = 0;
   logic       reset = 0;
   logic [7:0] mem [32];
   int         wcount = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   int         w0;
   logic [7:0] q [$];

   program_loader_if #(.ADDR_W(5)) bus ();
   program_loader #(.MEM_DEPTH(32), .ADDR_W(5), .SYNC_BYTE(8'hA5)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
         wcount <= wcount + 1;
      end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      int t = 0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check($sformatf("ready_for_%02h", b), bus.in_ready, 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic send_q(input int max_gap);
      foreach (q[i]) send(q[i], $urandom_range(0, max_gap));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_we"}, bus.mem_we, 0);
      check({tag, "_addr"}, bus.mem_addr, 0);
      check({tag, "_wdata"}, bus.mem_wdata, 0);
      check({tag, "_cpu_rst"}, bus.cpu_reset, 1);
      check({tag, "_done"}, bus.load_done, 0);
      check({tag, "_err"}, bus.load_error, 0);
      check({tag, "_ready"}, bus.in_ready, 0);
   endtask

   task automatic check_err_after(input string tag, input int w_exp);
      check({tag, "_err"}, bus.load_error, 1);
      check({tag, "_ready0"}, bus.in_ready, 0);
      check({tag, "_cpu_rst"}, bus.cpu_reset, 1);
      check({tag, "_nowrite"}, wcount, w_exp);
      @(posedge clk);
      #1 check({tag, "_ready1"}, bus.in_ready, 1);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1 check_reset_vals("rst");
      @(negedge clk);
      reset = 1'b1;
      #1 check("rst_rel_ready", bus.in_ready, 1);

      // good frame
      q = {8'hA5, 8'h03, 8'h02, 8'h11};
      send_q(0);
      send(8'h22, 0);
      check("a_we", bus.mem_we, 1);
      check("a_addr", bus.mem_addr, 4);
      check("a_wdata", bus.mem_wdata, 8'h22);
      send(8'hC8, 0);
      check("a_done", bus.load_done, 1);
      check("a_cpu_rst", bus.cpu_reset, 0);
      check("a_ready", bus.in_ready, 0);
      check("a_mem3", mem[3], 8'h11);
      check("a_mem4", mem[4], 8'h22);
      check("a_wcount", wcount, 2);

      // DONE ignores further input
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
      repeat (5) begin
         @(posedge clk);
         #1;
         check("hold_ready", bus.in_ready, 0);
         check("hold_we", bus.mem_we, 0);
         check("hold_done", bus.load_done, 1);
         check("hold_cpu_rst", bus.cpu_reset, 0);
      end
      bus.in_valid = 1'b0;
      check("hold_wcount", wcount, 2);

      // bad checksum then recovery
      do_reset();
      w0 = wcount;
      q = {8'hA5, 8'h03, 8'h02, 8'h11, 8'h22, 8'hC9};
      send_q(0);
      check_err_after("bad_chk", w0 + 2);
      check("bad_chk_sticky", bus.load_error, 1);
      send(8'hA5, 0);
      check("resync_err_clr", bus.load_error, 0);
      q = {8'h03, 8'h02, 8'h11, 8'h22, 8'hC8};
      send_q(0);
      check("retry_done", bus.load_done, 1);
      check("retry_cpu_rst", bus.cpu_reset, 0);

      // header rejections
      do_reset();
      w0 = wcount;
      send(8'hA5, 0);
      send(8'h20, 0);
      check_err_after("base_rsv", w0);
      q = {8'hA5, 8'h1F};
      send_q(0);
      send(8'h02, 0);
      check_err_after("len_oob", w0);
      q = {8'hA5, 8'h00};
      send_q(0);
      send(8'h00, 0);
      check_err_after("len_zero", w0);

      // full memory with junk prefix and gaps
      do_reset();
      w0 = wcount;
      q = {8'h00, 8'hFF, 8'h5A};
      send_q(0);
      check("junk_err", bus.load_error, 0);
      check("junk_ready", bus.in_ready, 1);
      q = {8'hA5, 8'h00, 8'h20};
      for (int i = 0; i < 32; i++) q.push_back(8'(i));
      q.push_back(8'hF0);
      send_q(2);
      check("full_wcount", wcount, w0 + 32);
      for (int i = 0; i < 32; i++) check($sformatf("full_mem%0d", i), mem[i], i);
      check("full_done", bus.load_done, 1);
      check("full_cpu_rst", bus.cpu_reset, 0);

      // reset mid-frame
      do_reset();
      w0 = wcount;
      q = {8'hA5, 8'h00, 8'h04, 8'hAA, 8'hBB};
      send_q(0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 check_reset_vals("mid");
      check("mid_wcount", wcount, w0 + 2);
      @(negedge clk);
      reset = 1'b1;
      q = {8'hA5, 8'h05, 8'h02, 8'h01, 8'h02, 8'hF6};
      send_q(1);
      check("post_done", bus.load_done, 1);
      check("post_mem5", mem[5], 8'h01);
      check("post_mem6", mem[6], 8'h02);
      check("post_mem1", mem[1], 8'hBB);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
